sum_packetizer: RTL and testbench
=================================

Name: sum_packetizer

Overview:
- Downstream stage of the 4-bit adder. Consumes adder sums through a valid/ready handshake.
- Accumulates a fixed-size group of sums into a running total and tracks the group maximum.
- Presents one result packet (total, max, sample count) to the next consumer with a valid/ready handshake.
- Group is N_SAMPLES sums; a flush input closes a partial group early.

Parameters:
- IN_W, 5, sum width (4-bit operands + carry).
- ACC_W, 12, accumulator/total width.
- N_SAMPLES, 4, sums per full packet (>=1).
- CNT_W, $clog2(N_SAMPLES+1), count field width (derived).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_sum valid
- in_ready  output  1  block can accept a sum
- in_sum  input  IN_W  adder result c, unsigned
- flush  input  1  close current partial group; single-cycle pulse or level
- out_valid  output  1  packet valid
- out_ready  input  1  consumer accepts packet
- out_total  output  ACC_W  sum of group samples
- out_max  output  IN_W  largest sample in group
- out_count  output  CNT_W  samples in packet (1..N_SAMPLES)
- out_sat  output  1  total saturated (feature-dependent)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - in_ready=0 during the reset cycle, 1 the following cycle.
  - out_valid=0, out_total=0, out_max=0, out_count=0, out_sat=0.
  - Accumulator, max, counter and state cleared.
- FSM states: ACCUM and HOLD. Reset enters ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs on in_valid&&in_ready.
  - On accept: acc+=zero-extended in_sum; max=max(max,in_sum); cnt+=1.
  - Go to HOLD when the accept makes cnt==N_SAMPLES, or when flush=1 and (cnt>0 or an accept occurs in that cycle).
  - On a simultaneous accept and flush, the sample is included before closing.
  - flush with cnt==0 and no accept is ignored.
- HOLD:
  - in_ready=0, out_valid=1.
  - Outputs are registered and stable until transfer.
  - Transfer occurs on out_valid&&out_ready. On transfer: clear acc/max/cnt/out_sat and return to ACCUM; in_ready=1 the next cycle.
  - flush is ignored in HOLD.
  - No bypass: a new sum is never accepted in the transfer cycle.
- Latency:
  - Closing accept/flush at edge t gives out_valid=1 after edge t, visible in cycle t+1.
  - Minimum packet period is N_SAMPLES+1 cycles (1 sum/cycle, out_ready held high).
- Arithmetic:
  - Unsigned.
  - Overflow at 2^ACC_W is governed by the optional feature.
  - out_max compares unsigned; ties keep the stored value.
- Reset mid-operation: partial group or pending packet is discarded; no packet is emitted for it.
- in_sum is sampled only on accept; the value while in_ready=0 is don't-care.

Optional Feature:
- Macro: PACKETIZER_SATURATE_EN.
- Defined:
  - If acc + in_sum >= 2^ACC_W, acc clamps to all-ones and a sticky sat flag is set.
  - out_sat reports the flag in HOLD; the flag clears on transfer or reset.
- Undefined:
  - Accumulator wraps modulo 2^ACC_W.
  - out_sat is tied to 0.

Test Plan:
1. Defaults; in_valid held 1, sums 3,7,1,5; out_ready=1. Expect in_ready=0 and out_valid=1 in the cycle after the 4th accept, with total=16, max=7, count=4. in_ready=1 one cycle after transfer.
2. Backpressure: complete a packet with out_ready=0 for 5 cycles. Expect out_valid held 1 with outputs stable, in_ready=0, and in_valid pulses ignored. Raise out_ready: single transfer, return to ACCUM.
3. Flush:
   - Sums 9,2, then flush alone: packet total=11, max=9, count=2.
   - Flush with cnt=0 and no sum: no packet.
   - Sum 4 with flush in the same cycle: packet total=4, count=1.
4. Reset mid-group: accept 2 sums, assert rst for 1 cycle. Expect all outputs 0 and no packet. Then 4 sums of 1 give total=4 (prior data discarded).
5. ACC_W=6, sums 30,30,30,2:
   - With PACKETIZER_SATURATE_EN: total=63, out_sat=1.
   - Without: total=92 mod 64=28, out_sat=0.
   - Next packet 1,1,1,1 gives total=4, out_sat=0.
6. Throughput: continuous in_valid with 12 random sums, out_ready=1. Expect 3 packets whose totals match a reference model, with exactly one idle in_ready cycle between groups.

Source files
------------

// File: rtl/sum_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : sum_packetizer
// Description : Collects adder sums into groups of N_SAMPLES. For each group
//               it builds a running total, the largest sample and a sample
//               count, then holds them as one result packet on a
//               valid/ready handshake. A flush closes a partial group early.
//               Optional macro PACKETIZER_SATURATE_EN makes the total clamp
//               at all-ones and sets a sticky out_sat flag. Without it the
//               total wraps and out_sat is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_packetizer #(
  parameter int IN_W      = 5,
  parameter int ACC_W     = 12,
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [IN_W-1:0]  out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [0:0]       ST_ACCUM    = 1'b0;
  localparam logic [0:0]       ST_HOLD     = 1'b1;
  localparam logic [CNT_W-1:0] C_N_SAMPLES = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_accept;
  logic             w_transfer;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_accept   = in_valid & in_ready;
  assign w_transfer = out_valid & out_ready;
  assign w_cnt_inc  = cnt_q + C_CNT_ONE;

`ifdef PACKETIZER_SATURATE_EN
  // One extra bit on the sum exposes the carry out of the accumulator.
  logic             sat_q, sat_d;
  logic [ACC_W:0]   w_sum_ext;
  assign w_sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(in_sum);
`else
  logic [ACC_W-1:0] w_sum_wrap;
  assign w_sum_wrap = acc_q + ACC_W'(in_sum);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: close the group on the last sample or on a non-empty flush
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: begin
        if ((w_accept && (w_cnt_inc == C_N_SAMPLES)) ||
            (flush && ((cnt_q != '0) || w_accept))) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_transfer) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Handshake outputs. Both are masked during reset, so a discarded packet
  // can never be seen as transferred.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_ACCUM: in_ready  = ~rst;
      ST_HOLD:  out_valid = ~rst;
      default: ;
    endcase
  end

  // Datapath next-state: accumulate on accept, clear on packet transfer
  always_comb begin
    acc_d = acc_q;
    max_d = max_q;
    cnt_d = cnt_q;
`ifdef PACKETIZER_SATURATE_EN
    sat_d = sat_q;
`endif
    if (w_accept) begin
      cnt_d = w_cnt_inc;
      // Strict compare: on a tie the stored value is kept.
      if (in_sum > max_q) begin
        max_d = in_sum;
      end
`ifdef PACKETIZER_SATURATE_EN
      if (w_sum_ext[ACC_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = w_sum_ext[ACC_W-1:0];
      end
`else
      acc_d = w_sum_wrap;
`endif
    end else if (w_transfer) begin
      acc_d = '0;
      max_d = '0;
      cnt_d = '0;
`ifdef PACKETIZER_SATURATE_EN
      sat_d = 1'b0;
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
`ifdef PACKETIZER_SATURATE_EN
      sat_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
`ifdef PACKETIZER_SATURATE_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign out_total = acc_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;
`ifdef PACKETIZER_SATURATE_EN
  assign out_sat   = sat_q & (state_q == ST_HOLD);
`else
  assign out_sat   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_packetizer
// Description : Directed self-checking bench for sum_packetizer. A second
//               instance with ACC_W=6 exercises overflow handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  // Instance A: default parameters
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_sat;
  logic [4:0]  in_sum, out_max;
  logic [11:0] out_total;
  logic [2:0]  out_count;
  // Instance B: ACC_W = 6
  logic        in_valid2, in_ready2, flush2, out_valid2, out_ready2, out_sat2;
  logic [4:0]  in_sum2, out_max2;
  logic [5:0]  out_total2;
  logic [2:0]  out_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_packetizer #(.IN_W(5), .ACC_W(12), .N_SAMPLES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_total(out_total), .out_max(out_max),
    .out_count(out_count), .out_sat(out_sat)
  );

  sum_packetizer #(.IN_W(5), .ACC_W(6), .N_SAMPLES(4)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sum(in_sum2), .flush(flush2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_total(out_total2), .out_max(out_max2),
    .out_count(out_count2), .out_sat(out_sat2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sum into instance A per cycle (out_ready left as set)
  task automatic feed(input int v);
    in_valid = 1'b1;
    in_sum   = 5'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic feed6(input int v);
    in_valid2 = 1'b1;
    in_sum2   = 5'(v);
    tick();
    in_valid2 = 1'b0;
  endtask

  int vals [12];
  int exp_tot [3];
  int idx, pkt, lows, cyc;
  bit took;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sum = '0; flush = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_sum2 = '0; flush2 = 1'b0; out_ready2 = 1'b0;

    // ---- Reset state ----
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_total", out_total, 0);
    chk("rst_max", out_max, 0);
    chk("rst_count", out_count, 0);
    chk("rst_sat", out_sat, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // ---- 1: basic group 3,7,1,5 ----
    out_ready = 1'b1;
    feed(3); feed(7); feed(1);
    chk("t1_no_valid_yet", out_valid, 0);
    feed(5);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_total", out_total, 16);
    chk("t1_max", out_max, 7);
    chk("t1_count", out_count, 4);
    chk("t1_sat", out_sat, 0);
    tick();
    chk("t1_after_xfer_valid", out_valid, 0);
    chk("t1_after_xfer_ready", in_ready, 1);

    // ---- 2: backpressure ----
    out_ready = 1'b0;
    feed(2); feed(8); feed(6); feed(1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_ready", in_ready, 0);
      chk("t2_hold_total", out_total, 17);
      chk("t2_hold_max", out_max, 8);
      chk("t2_hold_count", out_count, 4);
      in_valid = (i % 2) == 0;
      in_sum   = 5'd31;
      tick();
    end
    in_valid = 1'b0;
    chk("t2_hold_total_end", out_total, 17);
    out_ready = 1'b1;
    tick();
    chk("t2_xfer_valid", out_valid, 0);
    chk("t2_xfer_ready", in_ready, 1);
    tick();
    chk("t2_single_xfer", out_valid, 0);

    // ---- 3: flush ----
    feed(9); feed(2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3a_valid", out_valid, 1);
    chk("t3a_total", out_total, 11);
    chk("t3a_max", out_max, 9);
    chk("t3a_count", out_count, 2);
    tick();
    chk("t3a_xfer", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3b_empty_flush_valid", out_valid, 0);
    chk("t3b_empty_flush_ready", in_ready, 1);
    flush = 1'b1;
    feed(4);
    flush = 1'b0;
    chk("t3c_valid", out_valid, 1);
    chk("t3c_total", out_total, 4);
    chk("t3c_max", out_max, 4);
    chk("t3c_count", out_count, 1);
    tick();
    chk("t3c_xfer", out_valid, 0);

    // ---- 4: reset mid-group ----
    feed(7); feed(7);
    rst = 1'b1;
    tick();
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_total", out_total, 0);
    chk("t4_rst_max", out_max, 0);
    chk("t4_rst_count", out_count, 0);
    rst = 1'b0;
    tick();
    chk("t4_no_pkt", out_valid, 0);
    chk("t4_ready", in_ready, 1);
    feed(1); feed(1); feed(1); feed(1);
    chk("t4_valid", out_valid, 1);
    chk("t4_total", out_total, 4);
    chk("t4_count", out_count, 4);
    tick();

    // ---- 5: overflow on ACC_W=6 instance ----
    out_ready2 = 1'b1;
    feed6(30); feed6(30); feed6(30); feed6(2);
    chk("t5_valid", out_valid2, 1);
    chk("t5_max", out_max2, 30);
`ifdef PACKETIZER_SATURATE_EN
    chk("t5_total_sat", out_total2, 63);
    chk("t5_sat_flag", out_sat2, 1);
`else
    chk("t5_total_wrap", out_total2, 28);
    chk("t5_sat_flag", out_sat2, 0);
`endif
    tick();
    chk("t5_xfer", out_valid2, 0);
    feed6(1); feed6(1); feed6(1); feed6(1);
    chk("t5b_valid", out_valid2, 1);
    chk("t5b_total", out_total2, 4);
    chk("t5b_sat", out_sat2, 0);
    tick();

    // ---- 6: throughput with random sums ----
    for (int i = 0; i < 12; i++) vals[i] = int'($urandom_range(0, 31));
    for (int p = 0; p < 3; p++)
      exp_tot[p] = vals[4*p] + vals[4*p+1] + vals[4*p+2] + vals[4*p+3];
    idx = 0; pkt = 0; lows = 0; cyc = 0;
    in_valid = 1'b1;
    in_sum   = 5'(vals[0]);
    while (pkt < 3 && cyc < 60) begin
      took = in_ready && in_valid;
      tick();
      cyc++;
      if (took) idx++;
      if (idx < 12) in_sum = 5'(vals[idx]);
      else          in_valid = 1'b0;
      if (out_valid) begin
        chk("t6_total", out_total, exp_tot[pkt]);
        chk("t6_count", out_count, 4);
        pkt++;
      end
      if (!in_ready && idx < 12) lows++;
    end
    in_valid = 1'b0;
    chk("t6_packets", pkt, 3);
    chk("t6_idle_cycles", lows, 2);
    chk("t6_cycles", cyc, 14);
    tick();
    chk("t6_final_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
